// File: rtl/fir_decim_out.sv
// fir_decim_out: output stage behind the 37-tap FIR.
// Keeps every DECIM-th enabled sample, reduces it from IN_WL to OUT_WL bits,
// and queues the results in a first-word-fall-through FIFO that the consumer
// drains with valid/ready.
// Build option: define FIR_DECIM_ROUND_EN for round-half-up with saturation;
// when it is undefined the reduction is a plain arithmetic-shift truncation.
module fir_decim_out #(
  parameter int IN_WL  = 20,
  parameter int OUT_WL = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [IN_WL-1:0]           din,
  input  logic                       clr,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_WL-1:0]          m_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       sat
);

  localparam int S  = IN_WL - OUT_WL;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]     phase_q, phase_d;
  logic              s1_valid_q, s1_valid_d;
  logic [IN_WL-1:0]  s1_data_q, s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [OUT_WL-1:0] s2_data_q, s2_data_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              sat_q, sat_d;
  logic [OUT_WL-1:0] mem_q [DEPTH];

  logic              keep;
  logic              full;
  logic              do_rd;
  logic              do_wr;
  logic              drop;
  logic [OUT_WL-1:0] red_data;
  logic              red_sat;

`ifdef FIR_DECIM_ROUND_EN
  localparam logic [IN_WL:0] HALF = (IN_WL + 1)'(1) << (S - 1);
  logic [IN_WL:0]  rnd_sum;
  logic [OUT_WL:0] rnd_res;
  logic            unused_rnd_lsbs;
  assign unused_rnd_lsbs = ^rnd_sum[S-1:0];

  // Round half toward +inf with one guard bit, then clamp: the guard bit
  // differing from the output sign bit means the result left the range.
  always_comb begin
    rnd_sum  = {s1_data_q[IN_WL-1], s1_data_q} + HALF;
    rnd_res  = rnd_sum[IN_WL:S];
    red_sat  = rnd_res[OUT_WL] != rnd_res[OUT_WL-1];
    red_data = rnd_res[OUT_WL-1:0];
    if (red_sat) begin
      red_data = rnd_res[OUT_WL] ? {1'b1, {(OUT_WL-1){1'b0}}}
                                 : {1'b0, {(OUT_WL-1){1'b1}}};
    end
  end
`else
  logic unused_trunc_lsbs;
  assign unused_trunc_lsbs = ^s1_data_q[S-1:0];

  // Floor truncation: dropping the low bits always fits, so no clamp needed.
  always_comb begin
    red_data = s1_data_q[IN_WL-1:S];
    red_sat  = 1'b0;
  end
`endif

  assign full    = count_q == CW'(DEPTH);
  assign m_valid = count_q != '0;
  assign do_rd   = m_valid && m_ready;
  assign do_wr   = s2_valid_q && (!full || do_rd);
  assign drop    = s2_valid_q && full && !do_rd;
  assign keep    = en && (phase_q == '0);

  assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign sat     = sat_q;

  // Phase counter and the two pipeline stages; clr flushes everything.
  always_comb begin
    phase_d    = phase_q;
    s1_valid_d = keep && !clr;
    s1_data_d  = keep ? din : s1_data_q;
    s2_valid_d = s1_valid_q && !clr;
    s2_data_d  = s1_valid_q ? red_data : s2_data_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end
  end

  // FIFO pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q || drop;
    sat_d    = sat_q || (s1_valid_q && red_sat);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      sat_d    = 1'b0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      sat_q      <= sat_d;
    end
  end

  // FIFO storage; left unreset since count gates what is visible.
  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem_q[wr_ptr_q] <= s2_data_q;
  end

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out with default parameters (DECIM=4, DEPTH=8).
// Expected values are hand-computed; rounding/saturation expectations follow
// whether FIR_DECIM_ROUND_EN is defined.
module tb_fir_decim_out;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [19:0]        din;
  logic               clr;
  logic               m_valid;
  logic               m_ready;
  logic [15:0]        m_data;
  logic [3:0]         count;
  logic               ovf;
  logic               sat;

  int n_cmp = 0;
  int n_err = 0;

  fir_decim_out dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .ovf(ovf), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int v);
    en  = 1'b1;
    din = 20'(v);
    tick();
    en  = 1'b0;
  endtask

  // One kept sample followed by three enabled fillers: one full phase cycle.
  task automatic push_kept(input int v);
    push(v);
    for (int i = 0; i < 3; i++) push(0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    en  = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain(input string tag, input int exp);
    check({tag, "_valid"}, 32'(m_valid), 1);
    check(tag, 32'($signed(m_data)), exp);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  int rnd_in  [4] = '{24, -24, -8, 7};
`ifdef FIR_DECIM_ROUND_EN
  int rnd_exp [4] = '{2, -1, 0, 0};
  int sat_exp = 1;
`else
  int rnd_exp [4] = '{1, -2, -1, 0};
  int sat_exp = 0;
`endif
  int ovf_exp [8] = '{2, 3, 4, 5, 6, 7, 8, 10};

  initial begin
    rst_n = 1'b0; en = 1'b0; din = '0; clr = 1'b0; m_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data",  32'($signed(m_data)), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_sat",   32'(sat), 0);
    rst_n = 1'b1;

    // Decimation ramp: din = 16k, kept every 4th -> 0,4,8,...
    for (int k = 0; k < 20; k++) begin
      int e;
      en = 1'b1; din = 20'(16 * k); m_ready = 1'b1;
      tick();
      e = k + 1;
      check("ramp_valid", 32'(m_valid), (e >= 3 && e % 4 == 3) ? 1 : 0);
      check("ramp_count", 32'(count), (e >= 3 && e % 4 == 3) ? 1 : 0);
      if (e % 4 == 3) check("ramp_data", 32'($signed(m_data)), 4 * ((e - 3) / 4));
      $display("ramp edge %0d valid=%0d data=%0d", e, m_valid, $signed(m_data));
    end
    en = 1'b0; m_ready = 1'b0;

    // Rounding / truncation of small values.
    do_clr();
    for (int i = 0; i < 4; i++) push_kept(rnd_in[i]);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      drain("round_data", rnd_exp[i]);
      $display("round in=%0d exp=%0d", rnd_in[i], rnd_exp[i]);
    end
    check("round_empty", 32'(m_valid), 0);

    // Saturation at both extremes.
    do_clr();
    check("sat_cleared", 32'(sat), 0);
    push_kept(524287);
    check("sat_flag_pos", 32'(sat), sat_exp);
    push_kept(-524288);
    idle(3);
    drain("sat_pos", 32767);
    drain("sat_neg", -32768);
    check("sat_flag_end", 32'(sat), sat_exp);
    $display("saturation sat=%0d", sat);

    // Gapped enable: every other cycle disabled with a marker value.
    do_clr();
    for (int k = 0; k < 8; k++) begin
      push(16 * k);
      en = 1'b0; din = 20'(16 * 50);
      tick();
    end
    idle(3);
    drain("gap_first", 0);
    drain("gap_second", 4);
    check("gap_empty", 32'(m_valid), 0);
    $display("gapped enable done");

    // Full / overflow, then concurrent read+write while full.
    do_clr();
    for (int i = 1; i <= 9; i++) push_kept(16 * i);
    check("full_count", 32'(count), 8);
    check("full_ovf",   32'(ovf), 1);
    check("full_head",  32'($signed(m_data)), 1);
    push(160);
    idle(1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("rw_count", 32'(count), 8);
    check("rw_ovf",   32'(ovf), 1);
    for (int i = 0; i < 8; i++) begin
      drain("ovf_data", ovf_exp[i]);
      $display("drain %0d exp=%0d", i, ovf_exp[i]);
    end
    check("ovf_empty", 32'(count), 0);
    for (int i = 0; i < 3; i++) push(0);

    // clr with 3 queued entries and one sample in the pipeline.
    push_kept(16); push_kept(32); push_kept(48);
    check("pre_clr_count", 32'(count), 3);
    check("pre_clr_ovf",   32'(ovf), 1);
    push(64);
    clr = 1'b1; en = 1'b1; din = 20'(16 * 7);
    tick();
    clr = 1'b0; en = 1'b0;
    check("clr_count", 32'(count), 0);
    check("clr_valid", 32'(m_valid), 0);
    check("clr_ovf",   32'(ovf), 0);
    idle(4);
    check("clr_stale_valid", 32'(m_valid), 0);
    push_kept(80);
    drain("clr_after", 5);
    check("clr_after_empty", 32'(m_valid), 0);
    $display("clr mid-stream done");

    // Asynchronous reset with a full FIFO and a sample in flight.
    for (int i = 1; i <= 9; i++) push_kept(16 * i);
    check("pre_rst_ovf", 32'(ovf), 1);
    push(16 * 11);
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(m_valid), 0);
    check("arst_data",  32'($signed(m_data)), 0);
    check("arst_ovf",   32'(ovf), 0);
    tick();
    rst_n = 1'b1;
    idle(4);
    check("arst_stale_valid", 32'(m_valid), 0);
    push_kept(16 * 6);
    drain("arst_after", 6);
    $display("reset mid-stream done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage that sits directly downstream of the 37-tap FIR. It consumes the FIR's 20-bit signed accumulator output, one sample per enabled clock, and keeps every DECIM-th sample. Each kept sample is reduced to OUT_WL bits by rounding and saturation. Results are buffered in a small FIFO and drained by the consumer through a valid/ready handshake.

## Interface
- IN_WL, 20: input sample width, signed; matches the FIR output.
- OUT_WL, 16: output sample width, signed; must be < IN_WL.
- DECIM, 4: decimation factor, >= 1.
- DEPTH, 8: FIFO depth in entries, a power of two, >= 2.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  din is a valid FIR sample this cycle.
- din  in  IN_WL  FIR output sample, two's complement.
- clr  in  1  synchronous clear of the phase counter, FIFO and sticky flags; pipeline contents are discarded.
- m_valid  out  1  FIFO is non-empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- m_data  out  OUT_WL  FIFO head entry.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: a sample was dropped because the FIFO was full.
- sat  out  1  sticky: a sample was saturated.

## Operation
- Reset values: m_valid=0, m_data=0, count=0, ovf=0, sat=0; phase counter=0; pipeline valid bits=0.
- Phase counter:
  - Counts 0..DECIM-1 and advances only when en=1; wraps from DECIM-1 to 0.
  - A sample is kept when en=1 and phase==0. The first enabled sample after reset or clr is therefore kept.
  - DECIM=1 keeps every enabled sample.
- Stage 1: kept din is registered together with a valid bit.
- Stage 2, width reduction with S=IN_WL-OUT_WL:
  - Rounding: r = (x + 2^(S-1)) >>> S, arithmetic shift, i.e. round half toward +inf.
  - r is clamped to [-2^(OUT_WL-1), 2^(OUT_WL-1)-1]. If clamping occurs, sat is set.
  - The result is registered together with a valid bit.
- FIFO write: a stage-2 valid result is written at the next edge unless the FIFO is full.
- Full with no read in the same cycle: the sample is dropped, ovf is set, and contents are unchanged.
- Full with a read in the same cycle (m_ready=1): the read and the write both occur; count stays at DEPTH and no drop occurs.
- Empty with a write in the same cycle: the read side is ignored because m_valid=0; count goes to 1.
- Handshake:
  - A transfer occurs when m_valid & m_ready.
  - m_data is held stable while m_valid=1 and m_ready=0.
  - m_data is first-word-fall-through: the head entry is presented with no extra read latency.
- clr:
  - Has priority over all other operations.
  - Empties the FIFO, zeroes the phase counter, ovf and sat, and invalidates both pipeline stages.
  - A sample presented in the same cycle as clr is not kept.
- Reset mid-operation: all state returns to reset values immediately. No partial entry survives.

## Timing
- Latency from a kept din at edge N to the entry being visible in the FIFO (m_valid=1 if it was empty): 3 edges.
  - Edge N: stage 1.
  - Edge N+1: stage 2.
  - Edge N+2: FIFO write.
  - m_valid is high after edge N+2.
- Throughput: one FIFO write per cycle maximum, which is needed for DECIM=1. One read per cycle maximum.
- count updates at the same edge as the write or read that changes it.
- ovf and sat assert at the edge on which the drop or clamp is registered. They clear only on reset or clr.

## Configuration
- FIR_DECIM_ROUND_EN defined: rounding is done as specified above.
- FIR_DECIM_ROUND_EN undefined: truncation, r = x >>> S (floor), with no rounding adder.
  - Truncation cannot exceed the output range, so sat never asserts and the saturation logic may be omitted.
  - Latency is unchanged.

## Test plan
All scenarios use the default parameters unless stated.
- Decimation ramp: en=1 continuously, din=0,16,32,…, m_ready=1 -> m_data sequence 0,4,8,12…, first m_valid on the third edge after the first sample, one output every 4 cycles.
- Rounding, with FIR_DECIM_ROUND_EN, DECIM=1: din=24 -> 2; din=-24 -> -1; din=-8 -> 0; din=7 -> 0. Without the macro the same inputs give 1, -2, -1, 0.
- Saturation, with FIR_DECIM_ROUND_EN: din=524287 (0x7FFFF) -> m_data=32767 and sat=1; din=-524288 -> -32768 with no further sat event.
- Full/overflow, DECIM=1, m_ready=0, 9 kept samples 1..9 (×16) -> count=8, ovf=1, data 1..8 drained in order. Then drive m_ready=1 together with a new write while full -> both occur, count stays 8, no new drop.
- Gapped en: en toggling 1,0,1,0 -> phase advances only on en=1 cycles; kept samples are every 4th enabled sample.
- clr and reset mid-stream: assert clr while 3 entries are queued and one sample is in the pipeline -> next cycle count=0, m_valid=0, ovf=0, and no stale entry appears later. Repeat with rst_n low for one cycle -> same result, with m_data=0.
